triangle_rasterize: RTL and testbench

//  Consumer of projected triangles from the projection stage. Turns a screen-space triangle
//  (Q16.16 x/y in pixels, z depth) into the list of covered framebuffer pixels. Walks the clamped

---
 rtl/triangle_rasterize.sv | 239 +++++++++++++++++++++++
 tb/tb_triangle_rasterize.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_rasterize.sv
// Screen-space triangle rasterizer: walks the clamped bounding box one candidate per cycle
// and streams covered pixels with their edge weights and doubled area.
module triangle_rasterize #(
  parameter int COORD_WIDTH = 32,
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 180
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             start,
  input  logic [2:0][2:0][COORD_WIDTH-1:0] tri_verts,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       status,
  output logic [16:0]                      pixel_count,
  output logic                             pixel_valid,
  input  logic                             pixel_ready,
  output logic [$clog2(FB_WIDTH)-1:0]      pixel_x,
  output logic [$clog2(FB_HEIGHT)-1:0]     pixel_y,
  output logic signed [35:0]               pixel_w0,
  output logic signed [35:0]               pixel_w1,
  output logic signed [35:0]               pixel_w2,
  output logic signed [35:0]               tri_area
);
  localparam int IW = COORD_WIDTH - 16;
  localparam int EW = 36;
  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam logic signed [IW-1:0] XLIM = IW'(FB_WIDTH - 1);
  localparam logic signed [IW-1:0] YLIM = IW'(FB_HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AREA, S_BBOX, S_SCAN, S_DONE} state_t;

  state_t                 r_state;
  logic [COORD_WIDTH-1:0] r_qx [3];
  logic [COORD_WIDTH-1:0] r_qy [3];
  logic signed [IW-1:0]   r_ix [3];
  logic signed [IW-1:0]   r_iy [3];
  logic signed [IW:0]     r_sx [3];
  logic signed [IW:0]     r_sy [3];
  logic signed [EW-1:0]   r_w [3];
  logic signed [EW-1:0]   r_wrow [3];
  logic [XW-1:0]          r_x, r_xmin, r_xmax;
  logic [YW-1:0]          r_y, r_ymax;
  logic                   r_scan_end;

  logic signed [EW-1:0]   w_area, w_e0, w_e1, w_e2;
  logic signed [IW-1:0]   w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [IW-1:0]   w_cxmin, w_cxmax, w_cymin, w_cymax;
  logic                   w_offscreen, w_inside, w_last_x, w_last, w_adv, w_unused;

  function automatic logic signed [EW-1:0] edge_fn(
    input logic signed [IW-1:0] ax, ay, bx, by, px, py);
    logic signed [IW:0] dbx, dby, dpx, dpy;
    dbx = (IW+1)'(bx) - (IW+1)'(ax);
    dby = (IW+1)'(by) - (IW+1)'(ay);
    dpx = (IW+1)'(px) - (IW+1)'(ax);
    dpy = (IW+1)'(py) - (IW+1)'(ay);
    return EW'(dbx) * EW'(dpy) - EW'(dby) * EW'(dpx);
  endfunction

  function automatic logic signed [IW-1:0] min3(input logic signed [IW-1:0] a, b, c);
    logic signed [IW-1:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic signed [IW-1:0] max3(input logic signed [IW-1:0] a, b, c);
    logic signed [IW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic signed [EW-1:0] sext(input logic signed [IW:0] s);
    return EW'(s);
  endfunction

  always_comb begin
    w_area      = edge_fn(r_ix[0], r_iy[0], r_ix[1], r_iy[1], r_ix[2], r_iy[2]);
    w_xmin      = min3(r_ix[0], r_ix[1], r_ix[2]);
    w_xmax      = max3(r_ix[0], r_ix[1], r_ix[2]);
    w_ymin      = min3(r_iy[0], r_iy[1], r_iy[2]);
    w_ymax      = max3(r_iy[0], r_iy[1], r_iy[2]);
    w_cxmin     = w_xmin[IW-1] ? '0 : w_xmin;
    w_cymin     = w_ymin[IW-1] ? '0 : w_ymin;
    w_cxmax     = (w_xmax > XLIM) ? XLIM : w_xmax;
    w_cymax     = (w_ymax > YLIM) ? YLIM : w_ymax;
    w_offscreen = (w_cxmin > w_cxmax) || (w_cymin > w_cymax);
    w_e0        = edge_fn(r_ix[1], r_iy[1], r_ix[2], r_iy[2], w_cxmin, w_cymin);
    w_e1        = edge_fn(r_ix[2], r_iy[2], r_ix[0], r_iy[0], w_cxmin, w_cymin);
    w_e2        = edge_fn(r_ix[0], r_iy[0], r_ix[1], r_iy[1], w_cxmin, w_cymin);
  end

  assign w_inside = !r_w[0][EW-1] && !r_w[1][EW-1] && !r_w[2][EW-1];
  assign w_last_x = (r_x == r_xmax);
  assign w_last   = w_last_x && (r_y == r_ymax);
  assign w_adv    = !pixel_valid || pixel_ready;
  assign w_unused = ^{tri_verts[0][2], tri_verts[1][2], tri_verts[2][2],
                      r_qx[0][15:0], r_qx[1][15:0], r_qx[2][15:0],
                      r_qy[0][15:0], r_qy[1][15:0], r_qy[2][15:0],
                      w_cxmax[IW-1:XW], w_cymax[IW-1:YW]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= '0;
      pixel_count <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_w0    <= '0;
      pixel_w1    <= '0;
      pixel_w2    <= '0;
      tri_area    <= '0;
      r_scan_end  <= 1'b0;
      r_x         <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_y         <= '0;
      r_ymax      <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_qx[i]   <= '0;
        r_qy[i]   <= '0;
        r_ix[i]   <= '0;
        r_iy[i]   <= '0;
        r_sx[i]   <= '0;
        r_sy[i]   <= '0;
        r_w[i]    <= '0;
        r_wrow[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (pixel_valid && pixel_ready) pixel_count <= pixel_count + 17'd1;
      unique case (r_state)
        S_IDLE: if (start) begin
          for (int unsigned i = 0; i < 3; i++) begin
            r_qx[i] <= tri_verts[i][0];
            r_qy[i] <= tri_verts[i][1];
          end
          pixel_count <= '0;
          busy        <= 1'b1;
          r_state     <= S_SETUP;
        end
        S_SETUP: begin
          for (int unsigned i = 0; i < 3; i++) begin
            r_ix[i] <= r_qx[i][COORD_WIDTH-1:16];
            r_iy[i] <= r_qy[i][COORD_WIDTH-1:16];
          end
          r_state <= S_AREA;
        end
        S_AREA: if (w_area == '0) begin
          status  <= 2'd1;
          r_state <= S_DONE;
        end else begin
          tri_area <= w_area[EW-1] ? -w_area : w_area;
          if (w_area[EW-1]) begin
            r_ix[1] <= r_ix[2];
            r_ix[2] <= r_ix[1];
            r_iy[1] <= r_iy[2];
            r_iy[2] <= r_iy[1];
          end
          r_state <= S_BBOX;
        end
        S_BBOX: if (w_offscreen) begin
          status  <= 2'd2;
          r_state <= S_DONE;
        end else begin
          r_x       <= w_cxmin[XW-1:0];
          r_xmin    <= w_cxmin[XW-1:0];
          r_xmax    <= w_cxmax[XW-1:0];
          r_y       <= w_cymin[YW-1:0];
          r_ymax    <= w_cymax[YW-1:0];
          r_w[0]    <= w_e0;
          r_w[1]    <= w_e1;
          r_w[2]    <= w_e2;
          r_wrow[0] <= w_e0;
          r_wrow[1] <= w_e1;
          r_wrow[2] <= w_e2;
          // Per-edge increments: +1 in x subtracts dy of the edge, +1 in y adds its dx.
          r_sx[0]   <= (IW+1)'(r_iy[1]) - (IW+1)'(r_iy[2]);
          r_sy[0]   <= (IW+1)'(r_ix[2]) - (IW+1)'(r_ix[1]);
          r_sx[1]   <= (IW+1)'(r_iy[2]) - (IW+1)'(r_iy[0]);
          r_sy[1]   <= (IW+1)'(r_ix[0]) - (IW+1)'(r_ix[2]);
          r_sx[2]   <= (IW+1)'(r_iy[0]) - (IW+1)'(r_iy[1]);
          r_sy[2]   <= (IW+1)'(r_ix[1]) - (IW+1)'(r_ix[0]);
          r_scan_end <= 1'b0;
          r_state   <= S_SCAN;
        end
        S_SCAN: if (w_adv) begin
          if (r_scan_end) begin
            pixel_valid <= 1'b0;
            status      <= 2'd0;
            r_state     <= S_DONE;
          end else begin
            pixel_valid <= w_inside;
            if (w_inside) begin
              pixel_x  <= r_x;
              pixel_y  <= r_y;
              pixel_w0 <= r_w[0];
              pixel_w1 <= r_w[1];
              pixel_w2 <= r_w[2];
            end
            // An outside last candidate has nothing left to drain, so finish immediately.
            if (w_last) begin
              if (w_inside) r_scan_end <= 1'b1;
              else begin
                status  <= 2'd0;
                r_state <= S_DONE;
              end
            end else if (w_last_x) begin
              r_x <= r_xmin;
              r_y <= r_y + YW'(1);
              for (int unsigned i = 0; i < 3; i++) begin
                r_wrow[i] <= r_wrow[i] + sext(r_sy[i]);
                r_w[i]    <= r_wrow[i] + sext(r_sy[i]);
              end
            end else begin
              r_x <= r_x + XW'(1);
              for (int unsigned i = 0; i < 3; i++) r_w[i] <= r_w[i] + sext(r_sx[i]);
            end
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_rasterize.sv
// Scoreboard bench for triangle_rasterize: a direct-evaluation reference model predicts beats
// and completion records; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_triangle_rasterize;
  localparam int CW = 32;

  logic                    clk = 1'b0;
  logic                    rst_in = 1'b1;
  logic                    start = 1'b0;
  logic                    pixel_ready = 1'b1;
  logic [2:0][2:0][CW-1:0] tri_verts = '0;
  logic                    busy, done, pixel_valid;
  logic [1:0]              status;
  logic [16:0]             pixel_count;
  logic [8:0]              pixel_x;
  logic [7:0]              pixel_y;
  logic signed [35:0]      pixel_w0, pixel_w1, pixel_w2, tri_area;

  triangle_rasterize #(.COORD_WIDTH(CW), .FB_WIDTH(320), .FB_HEIGHT(180)) dut (
    .clk_in(clk), .rst_in(rst_in), .start(start), .tri_verts(tri_verts),
    .busy(busy), .done(done), .status(status), .pixel_count(pixel_count),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_w0(pixel_w0), .pixel_w1(pixel_w1), .pixel_w2(pixel_w2), .tri_area(tri_area)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; longint w0; longint w1; longint w2; longint area; } beat_t;
  typedef struct { int status; int count; int first_lat; int done_lat; } res_t;

  beat_t exp_q[$];
  res_t  res_q[$];
  beat_t mon_b;
  res_t  mon_r;
  int    checks = 0, errors = 0;
  int    cyc = 0, start_cyc = 0, beats_seen = 0;
  int    rdy_mode = 0, hold = 0;
  bit    first_pending = 1'b0, done_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: direct edge-function evaluation at every pixel of the clamped box.
  function automatic longint edge_e(input int ax, ay, bx, by, px, py);
    return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
  endfunction

  task automatic predict(input int qx[3], input int qy[3]);
    int ix[3], iy[3];
    int t, xmin, xmax, ymin, ymax, n;
    longint area, e0, e1, e2;
    res_t r;
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      ix[i] = qx[i] >>> 16;
      iy[i] = qy[i] >>> 16;
    end
    r.first_lat = -1;
    r.done_lat  = -1;
    r.count     = 0;
    area = edge_e(ix[0], iy[0], ix[1], iy[1], ix[2], iy[2]);
    if (area == 0) begin
      r.status = 1; r.done_lat = 3; res_q.push_back(r); return;
    end
    if (area < 0) begin
      t = ix[1]; ix[1] = ix[2]; ix[2] = t;
      t = iy[1]; iy[1] = iy[2]; iy[2] = t;
      area = -area;
    end
    xmin = ix[0]; xmax = ix[0]; ymin = iy[0]; ymax = iy[0];
    for (int i = 1; i < 3; i++) begin
      if (ix[i] < xmin) xmin = ix[i];
      if (ix[i] > xmax) xmax = ix[i];
      if (iy[i] < ymin) ymin = iy[i];
      if (iy[i] > ymax) ymax = iy[i];
    end
    if (xmin < 0) xmin = 0;
    if (ymin < 0) ymin = 0;
    if (xmax > 319) xmax = 319;
    if (ymax > 179) ymax = 179;
    if (xmin > xmax || ymin > ymax) begin
      r.status = 2; r.done_lat = 4; res_q.push_back(r); return;
    end
    n = 0;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++) begin
        e0 = edge_e(ix[1], iy[1], ix[2], iy[2], x, y);
        e1 = edge_e(ix[2], iy[2], ix[0], iy[0], x, y);
        e2 = edge_e(ix[0], iy[0], ix[1], iy[1], x, y);
        if (e0 >= 0 && e1 >= 0 && e2 >= 0) begin
          if (x == xmin && y == ymin) r.first_lat = 4;
          b.x = x; b.y = y; b.w0 = e0; b.w1 = e1; b.w2 = e2; b.area = area;
          exp_q.push_back(b);
          n++;
        end
      end
    r.status = 0;
    r.count  = n;
    res_q.push_back(r);
  endtask

  task automatic issue(input int qx[3], input int qy[3]);
    predict(qx, qy);
    @(posedge clk); #1;
    for (int v = 0; v < 3; v++) begin
      tri_verts[v][0] = qx[v];
      tri_verts[v][1] = qy[v];
      tri_verts[v][2] = $urandom;
    end
    start = 1'b1; beats_seen = 0; first_pending = 1'b1; done_seen = 1'b0; hold = 0;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_tri(input int x0, y0, x1, y1, x2, y2);
    int qx[3], qy[3];
    qx[0] = x0 <<< 16; qx[1] = x1 <<< 16; qx[2] = x2 <<< 16;
    qy[0] = y0 <<< 16; qy[1] = y1 <<< 16; qy[2] = y2 <<< 16;
    issue(qx, qy);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout act=no done exp=done within %0d cycles", budget);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beats_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (beats_seen < target) begin
      errors++;
      $display("FAIL beat_timeout act=%0d beats exp=%0d beats", beats_seen, target);
    end
  endtask

  task automatic check_count(input string tag, input int want);
    checks++;
    if (int'(pixel_count) != want) begin
      errors++;
      $display("FAIL %s pixel_count act=%0d exp=%0d", tag, pixel_count, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({busy, done, status, pixel_count, pixel_valid, pixel_x, pixel_y,
         pixel_w0, pixel_w1, pixel_w2, tri_area} != '0) begin
      errors++;
      $display("FAIL %s act busy=%0b done=%0b status=%0d count=%0d valid=%0b x=%0d y=%0d area=%0d exp all zero",
               tag, busy, done, status, pixel_count, pixel_valid, pixel_x, pixel_y, tri_area);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: pixel_ready = 1'($urandom_range(0, 1));
      2: if (beats_seen == 5 && hold < 10) begin
           pixel_ready = 1'b0;
           hold++;
         end else if (hold >= 10) pixel_ready = 1'($urandom_range(0, 1));
         else pixel_ready = 1'b1;
      default: pixel_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_in) begin
      if (pixel_valid && first_pending) begin
        first_pending = 1'b0;
        if (res_q.size() > 0 && res_q[0].first_lat >= 0) begin
          checks++;
          if (cyc - start_cyc != res_q[0].first_lat) begin
            errors++;
            $display("FAIL first_latency act=%0d exp=%0d", cyc - start_cyc, res_q[0].first_lat);
          end
        end
      end
      if (pixel_valid && pixel_ready) begin
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected act x=%0d y=%0d exp no beat", pixel_x, pixel_y);
        end else begin
          mon_b = exp_q.pop_front();
          if (int'(pixel_x) != mon_b.x || int'(pixel_y) != mon_b.y ||
              longint'(pixel_w0) != mon_b.w0 || longint'(pixel_w1) != mon_b.w1 ||
              longint'(pixel_w2) != mon_b.w2 || longint'(tri_area) != mon_b.area) begin
            errors++;
            $display("FAIL beat act x=%0d y=%0d w=%0d,%0d,%0d a=%0d exp x=%0d y=%0d w=%0d,%0d,%0d a=%0d",
                     pixel_x, pixel_y, pixel_w0, pixel_w1, pixel_w2, tri_area,
                     mon_b.x, mon_b.y, mon_b.w0, mon_b.w1, mon_b.w2, mon_b.area);
          end
        end
      end
      if (done) begin
        done_seen = 1'b1;
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected act=done status=%0d exp no done", status);
        end else begin
          mon_r = res_q.pop_front();
          if (int'(status) != mon_r.status || int'(pixel_count) != mon_r.count || busy ||
              exp_q.size() != 0 || (mon_r.done_lat >= 0 && cyc - start_cyc != mon_r.done_lat)) begin
            errors++;
            $display("FAIL done act status=%0d count=%0d busy=%0b lat=%0d left=%0d exp status=%0d count=%0d busy=0 lat=%0d left=0",
                     status, pixel_count, busy, cyc - start_cyc, exp_q.size(),
                     mon_r.status, mon_r.count, mon_r.done_lat);
          end
        end
      end
    end
  end

  initial begin
    int qx[3], qy[3];
    int cx, cy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_init");
    rst_in = 1'b0;

    run_tri(10, 10, 20, 10, 10, 20);
    wait_done(500);
    check_count("basic", 66);
    run_tri(10, 10, 10, 20, 20, 10);
    wait_done(500);
    run_tri(0, 0, 5, 5, 10, 10);
    wait_done(100);
    run_tri(400, 10, 420, 10, 410, 30);
    wait_done(100);
    run_tri(-10, -10, 10, -10, -10, 10);
    wait_done(500);

    // Stall at beat 5, then random ready; a start pulse mid-scan must be ignored.
    rdy_mode = 2;
    run_tri(10, 10, 20, 10, 10, 20);
    wait_beats(20, 2000);
    @(posedge clk); #1;
    tri_verts[0][0] = 100 <<< 16; tri_verts[1][0] = 150 <<< 16; tri_verts[2][0] = 100 <<< 16;
    tri_verts[0][1] = 100 <<< 16; tri_verts[1][1] = 100 <<< 16; tri_verts[2][1] = 150 <<< 16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3000);
    check_count("stall", 66);
    rdy_mode = 0;

    // Reset in the middle of a scan.
    run_tri(10, 10, 20, 10, 10, 20);
    wait_beats(10, 500);
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_scan");
    rst_in = 1'b0;
    exp_q.delete();
    res_q.delete();
    first_pending = 1'b0;
    done_seen = 1'b0;
    repeat (20) @(posedge clk);
    checks++;
    if (done_seen || pixel_valid) begin
      errors++;
      $display("FAIL after_reset act done_seen=%0b valid=%0b exp 0 0", done_seen, pixel_valid);
    end
    run_tri(10, 10, 20, 10, 10, 20);
    wait_done(500);
    check_count("rerun", 66);

    rdy_mode = 1;
    for (int t = 0; t < 12; t++) begin
      cx = int'($urandom_range(0, 360)) - 20;
      cy = int'($urandom_range(0, 220)) - 20;
      for (int v = 0; v < 3; v++) begin
        qx[v] = ((cx + int'($urandom_range(0, 40)) - 20) <<< 16) | int'($urandom_range(0, 65535));
        qy[v] = ((cy + int'($urandom_range(0, 40)) - 20) <<< 16) | int'($urandom_range(0, 65535));
      end
      issue(qx, qy);
      wait_done(20000);
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
